// File: rtl/binary_window_filter_if.sv
// Video mask stream interface for binary_window_filter.
// Carries the sync/mask input, the frame-synchronous config port and the aligned outputs.
interface binary_window_filter_if #(
  parameter int THR_W = 6
);
  logic             de;
  logic             hsync;
  logic             vsync;
  logic             mask;
  logic             cfg_we;
  logic [1:0]       cfg_mode;
  logic [THR_W-1:0] cfg_thr;
  logic             de_out;
  logic             hsync_out;
  logic             vsync_out;
  logic [23:0]      pixel_out;
  logic             cfg_pending;

  modport master (
    output de, hsync, vsync, mask, cfg_we, cfg_mode, cfg_thr,
    input  de_out, hsync_out, vsync_out, pixel_out, cfg_pending
  );

  modport slave (
    input  de, hsync, vsync, mask, cfg_we, cfg_mode, cfg_thr,
    output de_out, hsync_out, vsync_out, pixel_out, cfg_pending
  );
endinterface

// File: rtl/binary_window_filter.sv
// WINxWIN binary window filter (majority/erode/dilate/bypass) with frame-synchronous config.
// Optional per-frame foreground pixel counter enabled by defining FG_COUNT_EN.
module binary_window_filter #(
  parameter int WIN    = 5,
  parameter int H_SIZE = 83,
  parameter int THR_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  binary_window_filter_if.slave  bus
`ifdef FG_COUNT_EN
  ,
  output logic [23:0]            fg_count,
  output logic                   fg_count_valid
`endif
);
  localparam int               R       = (WIN - 1) / 2;
  localparam logic [THR_W-1:0] N_L     = THR_W'(WIN * WIN);
  localparam logic [THR_W-1:0] THR_DEF = THR_W'((WIN * WIN + 1) / 2);

  // Each stream element is {mask, de, hsync, vsync}
  logic [3:0]       w_row     [WIN];
  logic [3:0]       r_line    [WIN-1][H_SIZE];
  logic [3:0]       r_tap     [WIN][WIN];
  logic [THR_W-1:0] w_row_cnt [WIN];
  logic             w_ctx_ok;
  logic [THR_W-1:0] r_row_sum [WIN];
  logic             r_ok1;
  logic [3:0]       r_ctr1;
  logic [THR_W-1:0] w_sum;
  logic [THR_W-1:0] r_sum;
  logic             r_ok2;
  logic [3:0]       r_ctr2;
  logic [THR_W-1:0] w_thr_eff;
  logic             w_res;
  logic             w_vs_rise;
  logic             r_vs_d;
  logic [1:0]       r_act_mode;
  logic [1:0]       r_sh_mode;
  logic [THR_W-1:0] r_act_thr;
  logic [THR_W-1:0] r_sh_thr;
  logic             r_pending;
  logic             r_de_out;
  logic             r_hs_out;
  logic             r_vs_out;
  logic [23:0]      r_pix_out;

  // Row k of the window is the input stream delayed by k lines
  always_comb begin
    w_row[0] = {bus.mask, bus.de, bus.hsync, bus.vsync};
    for (int k = 1; k < WIN; k++) begin
      w_row[k] = r_line[k-1][H_SIZE-1];
    end
  end

  // Line delay shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WIN - 1; k++) begin
        for (int h = 0; h < H_SIZE; h++) begin
          r_line[k][h] <= 4'h0;
        end
      end
    end else begin
      for (int k = 0; k < WIN - 1; k++) begin
        r_line[k][0] <= w_row[k];
        for (int h = 1; h < H_SIZE; h++) begin
          r_line[k][h] <= r_line[k][h-1];
        end
      end
    end
  end

  // Window tap registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WIN; k++) begin
        for (int j = 0; j < WIN; j++) begin
          r_tap[k][j] <= 4'h0;
        end
      end
    end else begin
      for (int k = 0; k < WIN; k++) begin
        r_tap[k][0] <= w_row[k];
        for (int j = 1; j < WIN; j++) begin
          r_tap[k][j] <= r_tap[k][j-1];
        end
      end
    end
  end

  // Per-row mask counts and whole-window de check
  always_comb begin
    w_ctx_ok = 1'b1;
    for (int k = 0; k < WIN; k++) begin
      w_row_cnt[k] = '0;
      for (int j = 0; j < WIN; j++) begin
        w_row_cnt[k] = w_row_cnt[k] + THR_W'(r_tap[k][j][3]);
        w_ctx_ok     = w_ctx_ok & r_tap[k][j][2];
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < WIN; k++) begin
      w_sum = w_sum + r_row_sum[k];
    end
  end

  // Two popcount stages; centre tap and context flag travel alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WIN; k++) begin
        r_row_sum[k] <= '0;
      end
      r_ok1  <= 1'b0;
      r_ctr1 <= 4'h0;
      r_sum  <= '0;
      r_ok2  <= 1'b0;
      r_ctr2 <= 4'h0;
    end else begin
      for (int k = 0; k < WIN; k++) begin
        r_row_sum[k] <= w_row_cnt[k];
      end
      r_ok1  <= w_ctx_ok;
      r_ctr1 <= r_tap[R][R];
      r_sum  <= w_sum;
      r_ok2  <= r_ok1;
      r_ctr2 <= r_ctr1;
    end
  end

  // A threshold of 0 acts as 1; thresholds above N can never be reached
  always_comb begin
    w_thr_eff = (r_act_thr == '0) ? THR_W'(1) : r_act_thr;
    case (r_act_mode)
      2'd0:    w_res = r_ok2 & (r_sum >= w_thr_eff);
      2'd1:    w_res = r_ok2 & (r_sum == N_L);
      2'd2:    w_res = r_ok2 & (r_sum != '0);
      2'd3:    w_res = r_ctr2[3];
      default: w_res = 1'b0;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_out  <= 1'b0;
      r_hs_out  <= 1'b0;
      r_vs_out  <= 1'b0;
      r_pix_out <= 24'h000000;
    end else begin
      r_de_out  <= r_ctr2[2];
      r_hs_out  <= r_ctr2[1];
      r_vs_out  <= r_ctr2[0];
      r_pix_out <= w_res ? 24'hFFFFFF : 24'h000000;
    end
  end

  assign w_vs_rise = bus.vsync & ~r_vs_d;

  // Shadow/active config; a write in the boundary cycle waits for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d     <= 1'b0;
      r_act_mode <= 2'd0;
      r_sh_mode  <= 2'd0;
      r_act_thr  <= THR_DEF;
      r_sh_thr   <= THR_DEF;
      r_pending  <= 1'b0;
    end else begin
      r_vs_d <= bus.vsync;
      if (bus.cfg_we) begin
        r_sh_mode <= bus.cfg_mode;
        r_sh_thr  <= bus.cfg_thr;
        r_pending <= 1'b1;
      end else if (w_vs_rise) begin
        r_act_mode <= r_sh_mode;
        r_act_thr  <= r_sh_thr;
        r_pending  <= 1'b0;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

  assign bus.de_out      = r_de_out;
  assign bus.hsync_out   = r_hs_out;
  assign bus.vsync_out   = r_vs_out;
  assign bus.pixel_out   = r_pix_out;
  assign bus.cfg_pending = r_pending;

`ifdef FG_COUNT_EN
  logic        r_vso_d;
  logic [23:0] r_fg_cnt;
  logic [23:0] r_fg_count;
  logic        r_fg_valid;

  // Saturating foreground counter, latched on the output vsync rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vso_d    <= 1'b0;
      r_fg_cnt   <= 24'h000000;
      r_fg_count <= 24'h000000;
      r_fg_valid <= 1'b0;
    end else begin
      r_vso_d    <= r_vs_out;
      r_fg_valid <= 1'b0;
      if (r_vs_out && !r_vso_d) begin
        r_fg_count <= r_fg_cnt;
        r_fg_cnt   <= 24'h000000;
        r_fg_valid <= 1'b1;
      end else if (r_de_out && r_pix_out[0] && (r_fg_cnt != 24'hFFFFFF)) begin
        r_fg_cnt <= r_fg_cnt + 24'h000001;
      end else begin
        r_fg_cnt <= r_fg_cnt;
      end
    end
  end

  assign fg_count       = r_fg_count;
  assign fg_count_valid = r_fg_valid;
`endif
endmodule

// File: tb/tb_binary_window_filter.sv
// Self-checking bench for binary_window_filter (WIN=3, H_SIZE=16, 10x8 active frames).
// Expected outputs come from a 2-D image model of each frame, compared L clocks later.
module tb_binary_window_filter;
  localparam int WIN     = 3;
  localparam int H_SIZE  = 16;
  localparam int THR_W   = 6;
  localparam int L       = 20;
  localparam int ACT     = 10;
  localparam int ROWS    = 8;
  localparam int FR_ROWS = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  binary_window_filter_if #(.THR_W(THR_W)) bus ();
`ifdef FG_COUNT_EN
  logic [23:0] fg_count;
  logic        fg_count_valid;
`endif

  binary_window_filter #(.WIN(WIN), .H_SIZE(H_SIZE), .THR_W(THR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FG_COUNT_EN
    ,
    .fg_count       (fg_count),
    .fg_count_valid (fg_count_valid)
`endif
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n       = 0;
  int         base    = 0;
  logic [3:0] exp_v [0:8191];
  bit         img [ROWS][ACT];
  logic [1:0] m_mode, m_sh_mode;
  logic [5:0] m_thr, m_sh_thr;
  bit         m_pend, m_vs_prev;
  int         m_first_row = 0;

  task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [26:0] outs();
    return {bus.de_out, bus.hsync_out, bus.vsync_out, bus.pixel_out};
  endfunction

  task automatic model_reset();
    m_mode = 2'd0; m_sh_mode = 2'd0;
    m_thr  = 6'd5; m_sh_thr  = 6'd5;
    m_pend = 1'b0; m_vs_prev = 1'b0;
  endtask

  // Expected filter result for active pixel (r,c) under the model's active config
  function automatic logic exp_pix(input int r, input int c);
    int s;
    int t;
    if (m_mode == 2'd3) return img[r][c];
    if (r - 1 < m_first_row || r + 1 >= ROWS || c < 1 || c + 1 >= ACT) return 1'b0;
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += int'(img[r+dr][c+dc]);
    t = (m_thr == 6'd0) ? 1 : int'(m_thr);
    case (m_mode)
      2'd0:    return (s >= t);
      2'd1:    return (s == 9);
      2'd2:    return (s != 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic cycle(input logic de_i, input logic hs_i, input logic vs_i, input logic mk_i,
                       input logic pix_i, input logic we_i, input logic [1:0] md_i,
                       input logic [5:0] th_i);
    logic [3:0] e;
    bus.de = de_i; bus.hsync = hs_i; bus.vsync = vs_i; bus.mask = mk_i;
    bus.cfg_we = we_i; bus.cfg_mode = md_i; bus.cfg_thr = th_i;
    exp_v[n] = {de_i, hs_i, vs_i, pix_i};
    if (we_i) begin
      m_sh_mode = md_i; m_sh_thr = th_i; m_pend = 1'b1;
    end else if (vs_i && !m_vs_prev) begin
      m_mode = m_sh_mode; m_thr = m_sh_thr; m_pend = 1'b0;
    end
    m_vs_prev = vs_i;
    @(posedge clk);
    #1;
    e = (n - L >= base) ? exp_v[n-L] : 4'h0;
    check("stream", outs(), {e[3], e[2], e[1], {24{e[0]}}});
    check("cfg_pending", {26'd0, bus.cfg_pending}, {26'd0, m_pend});
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
  endtask

  task automatic set_cfg(input logic [1:0] md, input logic [5:0] th);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, md, th);
  endtask

  task automatic img_fill(input int kind);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < ACT; c++)
        case (kind)
          0:       img[r][c] = 1'b1;
          1:       img[r][c] = (r == 3 && c == 4);
          default: img[r][c] = bit'($urandom_range(1, 0));
        endcase
  endtask

  // One frame: vsync line, 8 active lines, 3 blank lines; optional cfg write or reset
  task automatic drive_frame(input int rst_row, input int we_row, input bit we_edge,
                             input logic [1:0] we_md, input logic [5:0] we_th);
    bit skip;
    m_first_row = 0;
    for (int fr = 0; fr < FR_ROWS; fr++) begin
      skip = 1'b0;
      for (int c = 0; c < H_SIZE; c++) begin
        logic de_i, mk_i, pix_i, we_i;
        int   r;
        r = fr - 1;
        if (!skip && rst_row >= 0 && r == rst_row && c == 5) begin
          rst_n = 1'b0;
          #1;
          check("async_reset_outputs", outs(), 27'd0);
          check("async_reset_pending", {26'd0, bus.cfg_pending}, 27'd0);
          repeat (H_SIZE - 5) @(posedge clk);
          #1;
          check("held_reset_outputs", outs(), 27'd0);
          rst_n = 1'b1;
          model_reset();
          base = n;
          m_first_row = r + 1;
          skip = 1'b1;
        end
        if (!skip) begin
          de_i = (fr >= 1 && fr <= ROWS && c < ACT);
          mk_i = 1'b0;
          pix_i = 1'b0;
          if (de_i) begin
            mk_i = img[r][c];
          end
          we_i = (we_edge && fr == 0 && c == 0) || (we_row >= 0 && r == we_row && c == 3);
          if (de_i && fr != 0) begin
            pix_i = exp_pix(r, c);
          end
          cycle(de_i, (c == 12 || c == 13), (fr == 0), mk_i, pix_i, we_i, we_md, we_th);
        end
      end
    end
  endtask

  initial begin
    bus.de = 1'b0; bus.hsync = 1'b0; bus.vsync = 1'b0; bus.mask = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_mode = 2'd0; bus.cfg_thr = 6'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 27'd0);
    check("reset_pending", {26'd0, bus.cfg_pending}, 27'd0);
    rst_n = 1'b1;
    idle(25);

    img_fill(0); drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);   // all ones, default majority thr 5
    img_fill(1); drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);   // isolated pixel, majority
    set_cfg(2'd2, 6'd5); drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);
    set_cfg(2'd3, 6'd5); drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);

    img_fill(2);
    set_cfg(2'd0, 6'd4);  drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);
    set_cfg(2'd0, 6'd0);  drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);
    set_cfg(2'd0, 6'd10); drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);
    set_cfg(2'd0, 6'd5);  drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);
    set_cfg(2'd1, 6'd5);  drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);
    img_fill(0);          drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);

    img_fill(2);
    set_cfg(2'd0, 6'd5);
    set_cfg(2'd1, 6'd9);  // last write wins
    set_cfg(2'd0, 6'd5);
    drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);
    drive_frame(-1, 3, 1'b0, 2'd2, 6'd5);                 // mid-frame write
    drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);                // dilate applies here
    drive_frame(-1, -1, 1'b1, 2'd3, 6'd5);                // write on the vsync edge
    drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);                // bypass applies here

    img_fill(0);
    set_cfg(2'd2, 6'd7);
    drive_frame(3, -1, 1'b0, 2'd0, 6'd0);                 // reset mid-line
    idle(10);
    drive_frame(-1, -1, 1'b0, 2'd0, 6'd0);                // defaults after reset
    idle(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
